data_access_buffer: RTL

DATA_ACCESS_BUFFER -- requirements
Module: data_access_buffer

---
 rtl/acker_da_pkg.sv | 18 +
 rtl/data_access_buffer_if.sv | 42 ++++
 rtl/da_sync_fifo.sv | 57 +++++
 rtl/data_access_buffer.sv | 72 +++++++
 4 files changed

// File: rtl/acker_da_pkg.sv
// Shared constants and entry layout for the data access buffer.
// The DA_SENSOR_FILTER_EN build option is handled in data_access_buffer and its interface.
package acker_da_pkg;

    localparam int unsigned DA_DATA_W = 14;
    localparam int unsigned DA_DEPTH  = 16;

    localparam logic [1:0] SENSOR_0 = 2'b00;
    localparam logic [1:0] SENSOR_1 = 2'b01;
    localparam logic [1:0] SENSOR_2 = 2'b10;
    localparam logic [1:0] SENSOR_3 = 2'b11;

    typedef struct packed {
        logic [1:0]           sensor;
        logic [DA_DATA_W-1:0] data;
    } da_entry_t;

endpackage

// File: rtl/data_access_buffer_if.sv
// Producer/consumer bus of the data access buffer.
// DA_SENSOR_FILTER_EN adds the sensor_mask input.
interface data_access_buffer_if #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] da_Data_in;
    logic              da_Data_in_valid;
    logic [1:0]        da_sensor_type;
    logic              da_Ready_for_Data_in;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_sensor;
    logic              rd_valid;
    logic [CNT_W-1:0]  fill_level;
    logic              empty;
    logic              full;
`ifdef DA_SENSOR_FILTER_EN
    logic [3:0]        sensor_mask;
`endif

    modport master (
`ifdef DA_SENSOR_FILTER_EN
        output sensor_mask,
`endif
        output da_Data_in, da_Data_in_valid, da_sensor_type, rd_req,
        input  da_Ready_for_Data_in, rd_data, rd_sensor, rd_valid,
               fill_level, empty, full
    );

    modport slave (
`ifdef DA_SENSOR_FILTER_EN
        input  sensor_mask,
`endif
        input  da_Data_in, da_Data_in_valid, da_sensor_type, rd_req,
        output da_Ready_for_Data_in, rd_data, rd_sensor, rd_valid,
               fill_level, empty, full
    );

endinterface

// File: rtl/da_sync_fifo.sv
// Single-clock FIFO storage with registered occupancy flags.
// Callers must not write when full nor read when empty.
module da_sync_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_entry,
    input  logic                     rd_en,
    output logic [W-1:0]             head_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Power-of-two depth: pointers wrap naturally at DEPTH-1 -> 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/data_access_buffer.sv
// ADC sample buffer: valid/ready write side, request/pulse read side.
// DA_SENSOR_FILTER_EN drops samples whose sensor_mask bit is clear.
module data_access_buffer
    import acker_da_pkg::*;
#(
    parameter int unsigned DATA_W = DA_DATA_W,
    parameter int unsigned DEPTH  = DA_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    data_access_buffer_if.slave  bus
);
    localparam int unsigned EW = DATA_W + 2;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          rst_done;
    logic          wr_xfer;
    logic          store;
    logic          rd_pop;
    logic [EW-1:0] head_c;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    assign bus.da_Ready_for_Data_in = rst_done & ~fifo_full;
    assign wr_xfer = bus.da_Data_in_valid & bus.da_Ready_for_Data_in;
`ifdef DA_SENSOR_FILTER_EN
    // Filtered samples are still acknowledged, just not stored
    assign store = wr_xfer & bus.sensor_mask[bus.da_sensor_type];
`else
    assign store = wr_xfer;
`endif
    // No fall-through: a read while empty is ignored even with a write pending
    assign rd_pop = bus.rd_req & ~fifo_empty;

    assign bus.fill_level = fifo_count;
    assign bus.empty      = fifo_empty;
    assign bus.full       = fifo_full;

    da_sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clock),
        .rst_n    (reset),
        .wr_en    (store),
        .wr_entry ({bus.da_sensor_type, bus.da_Data_in}),
        .rd_en    (rd_pop),
        .head_c   (head_c),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Read outputs hold the last popped entry between pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_done      <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
            bus.rd_sensor <= '0;
        end else begin
            rst_done     <= 1'b1;
            bus.rd_valid <= rd_pop;
            if (rd_pop) begin
                bus.rd_data   <= head_c[DATA_W-1:0];
                bus.rd_sensor <= head_c[EW-1:DATA_W];
            end
        end
    end

endmodule
